// File: rtl/mem_nibble_editor.sv
// mem_nibble_editor: DEPTH x WIDTH register file with a hex-digit editor front end.
//
// The user steps through addresses (VIEW), edits one hex digit at a time (EDIT) or sweeps
// the whole array to zero (CLEAR). Outputs feed a seven-segment stage: packed hex digits
// {addr, word} plus per-digit enables, with the digit under the cursor blinking in EDIT.
//
// Ports:
//   clk        system clock
//   reset_n    synchronous active-low reset
//   mode       0 VIEW, 1 EDIT, 2 CLEAR, 3 VIEW
//   inc, dec   single-cycle pulses: digit +1 / -1 (EDIT only)
//   nxt, prv   single-cycle pulses: move forward / back (address in VIEW, cursor in EDIT)
//   addr       current word address
//   word       mem[addr]
//   cursor     selected data digit, 0 = least significant
//   busy       CLEAR sweep in progress
//   disp_data  {addr zero-extended to whole digits, word}
//   disp_en    per-digit display enable, same order as disp_data
module mem_nibble_editor #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned BLINK_HALF = 12_500_000,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned NDATA     = WIDTH / 4,
    localparam int unsigned NADDR     = (AW + 3) / 4,
    localparam int unsigned CW        = (NDATA > 1) ? $clog2(NDATA) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [1:0]                   mode,
    input  logic                         inc,
    input  logic                         dec,
    input  logic                         nxt,
    input  logic                         prv,
    output logic [AW-1:0]                addr,
    output logic [WIDTH-1:0]             word,
    output logic [CW-1:0]                cursor,
    output logic                         busy,
    output logic [4*(NADDR+NDATA)-1:0]   disp_data,
    output logic [NADDR+NDATA-1:0]       disp_en
);

    localparam int unsigned BW = $clog2(BLINK_HALF);

    localparam logic [1:0] ModeEdit  = 2'd1;
    localparam logic [1:0] ModeClear = 2'd2;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] cursor_q, cursor_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [1:0]    mode_prev_q;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic             blink_force;

    logic             is_edit;
    logic             is_clear;
    logic             clear_entry;
    logic [AW-1:0]    addr_next;
    logic [AW-1:0]    addr_prev;
    logic [WIDTH-1:0] cur_word;
    logic [3:0]       cur_nib;
    logic [3:0]       new_nib;
    logic [CW+1:0]    nib_lsb;

    assign is_edit     = (mode == ModeEdit);
    assign is_clear    = (mode == ModeClear);
    assign clear_entry = is_clear && (mode_prev_q != ModeClear);

    // Explicit compare-and-wrap keeps non-power-of-2 DEPTH modulo correct.
    assign addr_next = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
    assign addr_prev = (addr_q == '0) ? AW'(DEPTH - 1) : addr_q - AW'(1);

    assign cur_word = mem_q[addr_q];
    assign nib_lsb  = {cursor_q, 2'b00};
    assign cur_nib  = cur_word[nib_lsb +: 4];
    assign new_nib  = inc ? (cur_nib + 4'd1) : (cur_nib - 4'd1);

    always_comb begin
        addr_d      = addr_q;
        cursor_d    = cursor_q;
        busy_d      = busy_q;
        ptr_d       = ptr_q;
        mem_we      = 1'b0;
        mem_waddr   = addr_q;
        mem_wdata   = cur_word;
        blink_force = 1'b0;

        if (is_clear) begin
            // Commands are ignored; only the sweep advances.
            if (clear_entry) begin
                busy_d = 1'b1;
                ptr_d  = '0;
            end else if (busy_q) begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                ptr_d     = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    busy_d   = 1'b0;
                    addr_d   = '0;
                    cursor_d = '0;
                end
            end
        end else begin
            // Leaving CLEAR aborts any sweep; commands in this cycle still apply.
            busy_d = 1'b0;
            if (is_edit) begin
                // Edit targets the pre-move addr/cursor; move lands in the same cycle.
                if (inc ^ dec) begin
                    mem_we               = 1'b1;
                    mem_wdata[nib_lsb +: 4] = new_nib;
                    blink_force          = 1'b1;
                end
                if (nxt && !prv) begin
                    blink_force = 1'b1;
                    if (cursor_q == CW'(NDATA - 1)) begin
                        cursor_d = '0;
                        addr_d   = addr_next;
                    end else begin
                        cursor_d = cursor_q + CW'(1);
                    end
                end else if (prv && !nxt) begin
                    blink_force = 1'b1;
                    if (cursor_q == '0) begin
                        cursor_d = CW'(NDATA - 1);
                        addr_d   = addr_prev;
                    end else begin
                        cursor_d = cursor_q - CW'(1);
                    end
                end
                if (mode_prev_q != ModeEdit) begin
                    blink_force = 1'b1;
                end
            end else begin
                if (nxt && !prv) begin
                    addr_d = addr_next;
                end else if (prv && !nxt) begin
                    addr_d = addr_prev;
                end
            end
        end
    end

    // Restart the blink visible-phase on activity so the cursor digit shows immediately.
    always_comb begin
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (blink_force) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            addr_q        <= '0;
            cursor_q      <= '0;
            busy_q        <= 1'b0;
            ptr_q         <= '0;
            mode_prev_q   <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            if (mem_we) begin
                mem_q[mem_waddr] <= mem_wdata;
            end
            addr_q        <= addr_d;
            cursor_q      <= cursor_d;
            busy_q        <= busy_d;
            ptr_q         <= ptr_d;
            mode_prev_q   <= mode;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    logic [4*NADDR-1:0] addr_ext;
    assign addr_ext = (4 * NADDR)'(addr_q);

    assign addr      = addr_q;
    assign word      = cur_word;
    assign cursor    = cursor_q;
    assign busy      = busy_q;
    assign disp_data = {addr_ext, cur_word};

    always_comb begin
        disp_en = '1;
        if (is_edit && !busy_q) begin
            disp_en[cursor_q] = blink_phase_q;
        end
    end

endmodule

// File: tb/tb_mem_nibble_editor.sv
module tb_mem_nibble_editor;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned BLINK_HALF = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  mode;
    logic        inc, dec, nxt, prv;
    logic [3:0]  addr;
    logic [15:0] word;
    logic [1:0]  cursor;
    logic        busy;
    logic [19:0] disp_data;
    logic [4:0]  disp_en;

    mem_nibble_editor #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .BLINK_HALF (BLINK_HALF)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .inc       (inc),
        .dec       (dec),
        .nxt       (nxt),
        .prv       (prv),
        .addr      (addr),
        .word      (word),
        .cursor    (cursor),
        .busy      (busy),
        .disp_data (disp_data),
        .disp_en   (disp_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model [16];

    task automatic sb_push(input string tag, input logic [31:0] val);
        sb_entry_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        sb_entry_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic i, input logic d, input logic n, input logic p);
        inc = i; dec = d; nxt = n; prv = p;
        cyc();
        inc = 1'b0; dec = 1'b0; nxt = 1'b0; prv = 1'b0;
    endtask

    // Walk every address in VIEW from addr 0 comparing against the model.
    task automatic walk_check(input string tag);
        for (int a = 0; a < 16; a++) begin
            sb_push($sformatf("%s_w%0d", tag, a), 32'(model[a]));
            sb_pop(32'(word));
            pulse(1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    // From addr 0 / cursor 0 in EDIT: inc+nxt on every digit of every word.
    task automatic fill_all();
        for (int a = 0; a < 16; a++) begin
            for (int c = 0; c < 4; c++) begin
                model[a][c*4 +: 4] = model[a][c*4 +: 4] + 4'd1;
                pulse(1'b1, 1'b0, 1'b1, 1'b0);
            end
        end
    endtask

    initial begin
        int busy_cnt;
        reset_n = 1'b0;
        mode = 2'd0;
        inc = 1'b0; dec = 1'b0; nxt = 1'b0; prv = 1'b0;
        for (int a = 0; a < 16; a++) model[a] = 16'h0000;

        // Reset then idle
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();
        sb_push("rst_addr", 0);        sb_pop(32'(addr));
        sb_push("rst_word", 0);        sb_pop(32'(word));
        sb_push("rst_cursor", 0);      sb_pop(32'(cursor));
        sb_push("rst_busy", 0);        sb_pop(32'(busy));
        sb_push("rst_disp_en", 5'h1F); sb_pop(32'(disp_en));
        sb_push("rst_disp_data", 0);   sb_pop(32'(disp_data));

        // VIEW
        sb_push("view_prv_wrap", 15);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        sb_pop(32'(addr));
        for (int i = 0; i < 17; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        sb_push("view_17nxt", 0);      sb_pop(32'(addr));
        sb_push("view_inc_ignored", 0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        sb_pop(32'(word));
        sb_push("view_cursor", 0);     sb_pop(32'(cursor));

        // EDIT
        mode = 2'd1;
        cyc();
        for (int i = 0; i < 17; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        sb_push("edit_17inc", 16'h0001); sb_pop(32'(word));
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        sb_push("edit_nxt_cursor", 1);   sb_pop(32'(cursor));
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        sb_push("edit_2dec", 16'h00E1);  sb_pop(32'(word));
        sb_push("edit_incdec", 16'h00E1);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        sb_pop(32'(word));
        sb_push("edit_disp_data", 20'h000E1); sb_pop(32'(disp_data));

        // Blink: inc forces phase visible, then toggles every BLINK_HALF cycles
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        sb_push("blink_force0", 5'h1F);  sb_pop(32'(disp_en));
        sb_push("edit_inc_d1", 16'h00F1); sb_pop(32'(word));
        cyc(); cyc(); cyc();
        sb_push("blink_e3", 5'h1F);      sb_pop(32'(disp_en));
        cyc();
        sb_push("blink_e4", 5'h1D);      sb_pop(32'(disp_en));
        cyc(); cyc(); cyc();
        sb_push("blink_e7", 5'h1D);      sb_pop(32'(disp_en));
        cyc();
        sb_push("blink_e8", 5'h1F);      sb_pop(32'(disp_en));
        cyc(); cyc(); cyc(); cyc();
        sb_push("blink_e12", 5'h1D);     sb_pop(32'(disp_en));
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        sb_push("blink_inc_force", 5'h1F); sb_pop(32'(disp_en));
        sb_push("edit_no_carry", 16'h0001); sb_pop(32'(word));

        // EDIT wrap across addresses
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        sb_push("wrap_prv_addr", 15);    sb_pop(32'(addr));
        sb_push("wrap_prv_cursor", 3);   sb_pop(32'(cursor));
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        sb_push("edit_digit3", 16'h1000); sb_pop(32'(word));
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        sb_push("wrap_nxt_addr", 0);     sb_pop(32'(addr));
        sb_push("wrap_nxt_cursor", 0);   sb_pop(32'(cursor));
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        sb_push("incnxt_word", 16'h0002); sb_pop(32'(word));
        sb_push("incnxt_cursor", 1);     sb_pop(32'(cursor));
        model[0]  = 16'h0002;
        model[15] = 16'h1000;

        // Fill memory with nonzero data
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        fill_all();
        sb_push("fill_addr", 0);         sb_pop(32'(addr));
        sb_push("fill_word0", 32'(model[0])); sb_pop(32'(word));
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        sb_push("pre_clear_addr", 15);   sb_pop(32'(addr));

        // Full CLEAR
        mode = 2'd2;
        cyc();
        busy_cnt = 0;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            busy_cnt++;
            cyc();
        end
        sb_push("clear_busy_cycles", 16); sb_pop(32'(busy_cnt));
        sb_push("clear_addr", 0);        sb_pop(32'(addr));
        sb_push("clear_cursor", 0);      sb_pop(32'(cursor));
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(); cyc();
        sb_push("clear_hold_busy", 0);   sb_pop(32'(busy));
        sb_push("clear_cmd_ignored", 0); sb_pop(32'(addr));
        mode = 2'd0;
        cyc();
        for (int a = 0; a < 16; a++) model[a] = 16'h0000;
        walk_check("full_clear");

        // Partial CLEAR: abort after 5 sweep cycles
        mode = 2'd1;
        cyc();
        fill_all();
        mode = 2'd2;
        cyc();
        for (int i = 0; i < 5; i++) cyc();
        mode = 2'd0;
        cyc();
        sb_push("abort_busy", 0);        sb_pop(32'(busy));
        sb_push("abort_addr", 0);        sb_pop(32'(addr));
        for (int a = 0; a < 5; a++) model[a] = 16'h0000;
        walk_check("part_clear");

        // Reset mid-sweep
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        mode = 2'd2;
        cyc(); cyc(); cyc();
        sb_push("sweep_busy", 1);        sb_pop(32'(busy));
        reset_n = 1'b0;
        cyc();
        sb_push("midrst_busy", 0);       sb_pop(32'(busy));
        sb_push("midrst_addr", 0);       sb_pop(32'(addr));
        sb_push("midrst_word", 0);       sb_pop(32'(word));
        sb_push("midrst_disp_en", 5'h1F); sb_pop(32'(disp_en));
        mode = 2'd0;
        reset_n = 1'b1;
        cyc();
        for (int a = 0; a < 16; a++) model[a] = 16'h0000;
        walk_check("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
